// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, default oversampling.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t IDLE   = 3'd0;
  localparam uart_state_t START  = 3'd1;
  localparam uart_state_t DATA   = 3'd2;
  localparam uart_state_t PARITY = 3'd3;
  localparam uart_state_t STOP   = 3'd4;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int OVERSAMPLE_DEF = 16;

  // Expected parity bit for a word of up to 8 bits (unused upper bits must be zero).
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Shift the asynchronous input through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop framing with error pulses.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = uart_pkg::PAR_NONE,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  import uart_pkg::*;

  // Sample points within a bit period: middle of the start bit, then one full period later.
  localparam logic [3:0] S_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] N_LAST = 3'(DATA_BITS - 1);
  localparam logic       HAS_PARITY = (PARITY != PAR_NONE);

  logic                 w_rx_s;
  uart_state_t          r_state;
  uart_state_t          w_state_next;
  logic [3:0]           r_s_cnt;
  logic [2:0]           r_n_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_armed;
  logic                 r_par_bit;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_data_valid;
  logic                 r_frame_err;
  logic                 r_parity_err;

  logic                 w_start_det;
  logic                 w_mid_start;
  logic                 w_data_smp;
  logic                 w_last_bit;
  logic                 w_par_smp;
  logic                 w_stop_smp;
  logic                 w_busy;
  logic                 w_par_exp;
  logic [7:0]           w_shift8;

  // Line reads idle (high) while in reset so no false start appears on release.
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (w_rx_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic; every transition except start detection waits for a sample tick.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_start_det) begin
          w_state_next = START;
        end
      end
      START: begin
        if (w_mid_start) begin
          w_state_next = w_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_last_bit) begin
          w_state_next = HAS_PARITY ? uart_pkg::PARITY : STOP;
        end
      end
      uart_pkg::PARITY: begin
        if (w_par_smp) begin
          w_state_next = STOP;
        end
      end
      STOP: begin
        if (w_stop_smp) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // FSM outputs: per-state sampling strobes and the busy flag.
  always_comb begin
    w_start_det = (r_state == IDLE) && r_armed && !w_rx_s;
    w_mid_start = (r_state == START) && tick && (r_s_cnt == S_MID);
    w_data_smp  = (r_state == DATA) && tick && (r_s_cnt == S_LAST);
    w_last_bit  = w_data_smp && (r_n_cnt == N_LAST);
    w_par_smp   = (r_state == uart_pkg::PARITY) && tick && (r_s_cnt == S_LAST);
    w_stop_smp  = (r_state == STOP) && tick && (r_s_cnt == S_LAST);
    w_busy      = (r_state != IDLE);
  end

  // Oversample and bit counters; the sample counter only moves on ticks while framing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_cnt <= '0;
      r_n_cnt <= '0;
    end else if (w_start_det) begin
      r_s_cnt <= '0;
    end else if (w_mid_start) begin
      r_s_cnt <= '0;
      r_n_cnt <= '0;
    end else if (w_data_smp) begin
      r_s_cnt <= '0;
      r_n_cnt <= r_n_cnt + 3'd1;
    end else if (w_par_smp || w_stop_smp) begin
      r_s_cnt <= '0;
    end else if (w_busy && tick) begin
      r_s_cnt <= r_s_cnt + 4'd1;
    end
  end

  // Data shift register (LSB arrives first, so shift right into the MSB) and parity capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_par_bit <= 1'b0;
    end else begin
      if (w_data_smp) begin
        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
      end
      if (w_par_smp) begin
        r_par_bit <= w_rx_s;
      end
    end
  end

  // Arming: a framing error disarms so a held-low line (break) yields only one error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
    end else if (w_stop_smp && !w_rx_s) begin
      r_armed <= 1'b0;
    end else if ((r_state == IDLE) && w_rx_s) begin
      r_armed <= 1'b1;
    end
  end

  assign w_shift8  = 8'(r_shift);
  assign w_par_exp = parity_bit(w_shift8, PARITY);

  // Result registers: word load and one-clock status pulses on the stop-bit sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_data_valid <= w_stop_smp && w_rx_s;
      r_frame_err  <= w_stop_smp && !w_rx_s;
      r_parity_err <= w_stop_smp && w_rx_s && HAS_PARITY && (r_par_bit != w_par_exp);
      if (w_stop_smp && w_rx_s) begin
        r_data_out <= r_shift;
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign busy       = w_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames against a frame-level model.
module tb_uart_rx;

  localparam int BIT_CLKS = 240;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       rx;
  logic       rx_p;
  logic [7:0] dout0, dout1;
  logic       dv0, fe0, perr0, busy0;
  logic       dv1, fe1, perr1, busy1;

  typedef struct packed {
    logic       kind;   // 0 = good word, 1 = framing error
    logic [7:0] data;
    logic       perr;
  } ev_t;

  ev_t  obs_q0[$], obs_q1[$], exp_q0[$], exp_q1[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  int   valid_cyc = 0;
  int   start_cyc = 0;
  int   overlap = 0;
  int   stray_perr = 0;
  logic meas_en = 1'b0;
  logic busy_prev = 1'b0;
  int   low_run = 0;
  int   runs[$];
  logic [7:0] last_good [2];

  always #5 clk = ~clk;

  uart_rx #(.DATA_BITS(8), .PARITY(0), .OVERSAMPLE(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx),
    .data_out(dout0), .data_valid(dv0), .frame_err(fe0), .parity_err(perr0), .busy(busy0)
  );

  uart_rx #(.DATA_BITS(8), .PARITY(1), .OVERSAMPLE(16)) u_dut_par (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx_p),
    .data_out(dout1), .data_valid(dv1), .frame_err(fe1), .parity_err(perr1), .busy(busy1)
  );

  // Baud tick: one clock out of every 15.
  initial begin
    tick = 1'b0;
    forever begin
      repeat (14) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (dv0) begin
      obs_q0.push_back(ev_t'{kind: 1'b0, data: dout0, perr: perr0});
      valid_cyc = cyc;
    end
    if (fe0) obs_q0.push_back(ev_t'{kind: 1'b1, data: 8'h00, perr: perr0});
    if (dv1) obs_q1.push_back(ev_t'{kind: 1'b0, data: dout1, perr: perr1});
    if (fe1) obs_q1.push_back(ev_t'{kind: 1'b1, data: 8'h00, perr: perr1});
    if ((dv0 && fe0) || (dv1 && fe1)) overlap++;
    if ((perr0 && !dv0) || (perr1 && !dv1)) stray_perr++;
    if (meas_en) begin
      if (!busy0) low_run++;
      else if (!busy_prev && low_run > 0) begin
        runs.push_back(low_run);
        low_run = 0;
      end
    end else begin
      low_run = 0;
    end
    busy_prev = busy0;
  end

  // Watchdog: the run is timed, but guard against anything unexpected.
  initial begin
    repeat (100000) @(negedge clk);
    $display("FAIL watchdog: cycle budget exceeded, observed=%0d required<100000", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input int sel, input logic b);
    if (sel == 0) rx = b;
    else rx_p = b;
  endtask

  task automatic hold_bit(input int sel, input logic b);
    @(negedge clk);
    drive(sel, b);
    repeat (BIT_CLKS - 1) @(negedge clk);
  endtask

  task automatic idle(input int sel, input int n_bits);
    if (n_bits > 0) begin
      @(negedge clk);
      drive(sel, 1'b1);
      repeat (n_bits * BIT_CLKS - 1) @(negedge clk);
    end
  endtask

  // Drive one frame and record what a correct receiver must report for it.
  task automatic send_frame(input int sel, input logic [7:0] d, input logic par_en,
                            input logic par, input logic stop);
    ev_t e;
    int  ones;
    $display("frame dut%0d data=%02h par_en=%0b par=%0b stop=%0b", sel, d, par_en, par, stop);
    hold_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) hold_bit(sel, d[i]);
    if (par_en) hold_bit(sel, par);
    hold_bit(sel, stop);
    ones = $countones(d);
    if (stop) begin
      e.kind = 1'b0;
      e.data = d;
      // Even parity: the parity bit makes the total count of ones even.
      e.perr = par_en && (((ones + int'(par)) % 2) != 0);
      last_good[sel] = d;
    end else begin
      e = ev_t'{kind: 1'b1, data: 8'h00, perr: 1'b0};
    end
    if (sel == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  task automatic check_dut(input int sel, input string tag);
    ev_t o[$], e[$];
    if (sel == 0) begin
      o = obs_q0; e = exp_q0; obs_q0.delete(); exp_q0.delete();
    end else begin
      o = obs_q1; e = exp_q1; obs_q1.delete(); exp_q1.delete();
    end
    chk({tag, "_count"}, o.size(), e.size());
    for (int i = 0; i < e.size() && i < o.size(); i++)
      chk({tag, "_event"}, {22'd0, o[i]}, {22'd0, e[i]});
  endtask

  initial begin
    logic [7:0] d;
    logic       stop, par;
    rst_n = 1'b0;
    rx    = 1'b1;
    rx_p  = 1'b1;
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    repeat (5) @(negedge clk);
    chk("rst_data_out", dout0, 32'h0);
    chk("rst_flags", {dv0, fe0, perr0, busy0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);

    // 1: single 8N1 frame, with latency from the start edge
    start_cyc = cyc;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    check_dut(0, "s1");
    chk("s1_latency", ((valid_cyc - start_cyc) inside {[2262:2292]}), 32'h1);
    chk("s1_data_out", dout0, 32'hA5);

    // 2: back-to-back frames, busy gaps are short
    idle(0, 1);
    meas_en = 1'b1;
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    meas_en = 1'b0;
    check_dut(0, "s2");
    chk("s2_busy_runs", runs.size(), 32'd3);
    if (runs.size() == 3) begin
      chk("s2_gap1", (runs[1] inside {[110:140]}), 32'h1);
      chk("s2_gap2", (runs[2] inside {[110:140]}), 32'h1);
    end
    runs.delete();

    // 3: short low glitch is rejected
    idle(0, 2);
    @(negedge clk);
    rx = 1'b0;
    repeat (60) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check_dut(0, "s3");
    chk("s3_busy", busy0, 32'h0);

    // 4: bad stop bit then break; one error, no restart until the line idles
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
    repeat (3000) @(negedge clk);
    check_dut(0, "s4_break");
    chk("s4_data_held", dout0, {24'd0, last_good[0]});
    chk("s4_busy", busy0, 32'h0);
    idle(0, 2);
    send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1);
    check_dut(0, "s4_recover");

    // random 8N1 frames, some with a bad stop bit
    for (int k = 0; k < 6; k++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(0, d, 1'b0, 1'b0, stop);
      if (!stop) idle(0, 1);
      else idle(0, int'($urandom_range(0, 1)));
      check_dut(0, "rand");
      chk("rand_data_out", dout0, {24'd0, last_good[0]});
    end

    // 5: even parity instance
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    check_dut(1, "s5_bad_par");
    chk("s5_data_out", dout1, 32'h07);
    idle(1, 1);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    check_dut(1, "s5_good_par");
    for (int k = 0; k < 4; k++) begin
      d   = 8'($urandom_range(0, 255));
      par = 1'($urandom_range(0, 1));
      idle(1, 1);
      send_frame(1, d, 1'b1, par, 1'b1);
      check_dut(1, "rand_par");
    end
    check_dut(0, "s5_other_quiet");

    // 6: reset in the middle of a data bit
    idle(0, 1);
    hold_bit(0, 1'b0);
    hold_bit(0, 1'b1);
    hold_bit(0, 1'b1);
    @(negedge clk);
    rx = 1'b0;
    repeat (100) @(negedge clk);
    chk("s6_busy_mid", busy0, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_data_out", dout0, 32'h0);
    chk("s6_rst_flags", {dv0, fe0, perr0, busy0}, 32'h0);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    idle(0, 2);
    check_dut(0, "s6_after_rst");
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
    check_dut(0, "s6");

    chk("no_overlap", overlap, 32'h0);
    chk("no_stray_perr", stray_perr, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver that consumes the 16x oversampling `tick` from the baud generator.
- Frames the serial `rx` line into parallel bytes, with optional parity checking.
- Sits between the pad/IO ring and the SoC UART peripheral register block.
- Reports framing and parity errors as one-clock pulses alongside the data strobe.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8), LSB first.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- OVERSAMPLE, 16, ticks per bit period; must match the baud generator.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- tick, input, 1, one-clk pulse at 16x the baud rate, from the baud generator.
- rx, input, 1, asynchronous serial line; idle high.
- data_out, output, DATA_BITS, last received word; held until the next word completes.
- data_valid, output, 1, one-clk pulse: data_out was updated with a good frame.
- frame_err, output, 1, one-clk pulse: stop bit sampled low.
- parity_err, output, 1, one-clk pulse: parity mismatch (only when PARITY != 0).
- busy, output, 1, high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - data_out=0; data_valid, frame_err, parity_err, busy = 0.
  - FSM in IDLE; counters cleared.
  - Synchronizer flops reset to 1, so the line reads as idle.
- Input synchronization: rx passes through a 2-FF synchronizer; every reference to rx below means the synchronized value rx_s.
- Time base:
  - The sample counter s_cnt (4 bits) advances only on clk edges where tick=1.
  - Cycles without tick change no state, except that IDLE start detection and rearm run every clk.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If armed and rx_s=0: go to START, s_cnt=0.
  - armed is set whenever rx_s=1 is seen in IDLE.
- START:
  - On the tick where s_cnt=7 (mid start bit):
    - If rx_s=0: s_cnt=0, go to DATA, n_cnt=0.
    - Else (glitch/false start): return to IDLE with no outputs.
- DATA:
  - On the tick where s_cnt=15: shift rx_s into the MSB of the shift register (right shift), s_cnt=0, n_cnt+1.
  - After DATA_BITS samples: go to PARITY if PARITY != 0, else STOP.
- PARITY:
  - On the tick where s_cnt=15: capture the parity bit and go to STOP.
  - Expected bit = XOR of data (even) or its inverse (odd).
- STOP, on the tick where s_cnt=15:
  - rx_s=1: load data_out and pulse data_valid on the next clk (registered, exactly 1 clk wide). parity_err pulses in the same cycle on a mismatch; data_out is still loaded.
  - rx_s=0: pulse frame_err and clear armed; data_out is unchanged; data_valid stays 0.
  - Either way, go to IDLE.
- Latency: data_valid rises 1 clk after the tick that samples the mid stop bit, about 9.5 bit periods after the start edge for 8N1.
- Break condition (rx held low): exactly one frame_err pulse, then no new start until rx_s has been seen high in IDLE.
- Pulse exclusivity: data_valid and frame_err are never high in the same cycle. parity_err may coincide with data_valid only.
- Counter widths:
  - s_cnt is 4 bits and wraps 15→0 naturally.
  - n_cnt is 3 bits, compared against DATA_BITS-1.
- Reset mid-frame: everything is cleared immediately, with no spurious pulse on deassertion. If rx is low at reset release, the block waits for rx_s=1 before arming.
- tick stuck at 0: the FSM freezes and busy stays high; this is not an error.

Decomposition:
- Package uart_pkg holds:
  - State encoding localparams: IDLE/START/DATA/PARITY/STOP.
  - Parity mode constants: PAR_NONE/PAR_EVEN/PAR_ODD.
  - Default OVERSAMPLE.
- The package is shared with the planned uart_tx.
- Sub-module sync_2ff (1-bit, reset value parameter) for rx; reusable elsewhere.

Test Plan:
- Bench timing for all scenarios: tick every 15 clks, bit period 240 clks.
- Scenario 1: 8N1 frame carrying 0xA5 → data_out=0xA5; data_valid is one pulse about 2280 clks after the start edge; no error pulses.
- Scenario 2: back-to-back frames 0x00, 0xFF, 0x3C with no idle gap → three data_valid pulses with data in order; busy drops only briefly between frames.
- Scenario 3: 60-clk low glitch on idle rx → no outputs; FSM returns to IDLE.
- Scenario 4: frame 0x55 with stop bit driven 0, then rx held low for 3000 clks → one frame_err pulse; data_out keeps the previous value; no restart until rx goes high, then 0x12 is received correctly.
- Scenario 5: PARITY=1 (even), 0x07 sent with parity bit 0 → data_valid and parity_err pulse together; data_out=0x07. Same frame with parity bit 1 → data_valid only.
- Scenario 6: rst_n asserted mid-DATA of 0xC3 → all outputs 0 immediately. After release, with rx idle high, the next frame 0x81 is received cleanly.
